// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin search used by the memory arbiter.
// rr_pick scans from ptr+1 modulo n and returns the first set request.
package mem_arb_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input int unsigned          n);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            cand = (32'(ptr) + i) % n;
            if (i <= n && !res.found && req[cand[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after last_ptr, wrapping.
// Shared by the idle pick and the back-to-back pick in mem_arbiter.
module rr_select
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_ptr,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any
);

    logic [MAX_REQ-1:0]   req_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    rr_pick_t             pick;

    always_comb begin
        req_ext                 = '0;
        req_ext[NUM_REQ-1:0]    = req;
        ptr_ext                 = '0;
        ptr_ext[ID_WIDTH-1:0]   = last_ptr;
        pick                    = rr_pick(req_ext, ptr_ext, NUM_REQ);
        winner                  = ID_WIDTH'(pick.idx);
        any                     = pick.found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Holds the grant FSM, the fairness pointer and the read-response routing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wr_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [WIDTH-1:0]              rsp_data_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wr_data_o,
    input  logic                          mem_ready_i,
    input  logic [WIDTH-1:0]              mem_rd_data_i,
    output logic [ID_WIDTH-1:0]           gnt_id_o,
    output logic                          busy_o
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e          state, state_nxt;
    logic [ID_WIDTH-1:0] gnt_id, gnt_id_nxt;
    logic [ID_WIDTH-1:0] last_ptr;
    logic [ID_WIDTH-1:0] pick_ptr, pick_id;
    logic [NUM_REQ-1:0]  pick_req, gnt_oh;
    logic                pick_any;
    logic                accept;
    logic                rsp_pend;
    logic [ID_WIDTH-1:0] rsp_id;

    assign gnt_oh = ONE << gnt_id;
    assign accept = (state == BUSY) && mem_ready_i;

    // While busy the owner is masked and the search starts after it, which is
    // exactly where last_ptr will point once the current transfer is accepted.
    always_comb begin
        pick_req = req_valid_i;
        pick_ptr = last_ptr;
        if (state == BUSY) begin
            pick_req = req_valid_i & ~gnt_oh;
            pick_ptr = gnt_id;
        end
    end

    rr_select #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_select (
        .req      (pick_req),
        .last_ptr (pick_ptr),
        .winner   (pick_id),
        .any      (pick_any)
    );

    always_comb begin
        state_nxt  = state;
        gnt_id_nxt = gnt_id;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt  = BUSY;
                    gnt_id_nxt = pick_id;
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    if (pick_any) begin
                        gnt_id_nxt = pick_id;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_id   <= '0;
            last_ptr <= ID_WIDTH'(NUM_REQ - 1);
            rsp_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt_id   <= gnt_id_nxt;
            rsp_pend <= accept && !mem_wr_rd_o;
            if (accept) begin
                last_ptr <= gnt_id;
            end
        end
    end

    // Only meaningful while rsp_pend is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept && !mem_wr_rd_o) begin
            rsp_id <= gnt_id;
        end
    end

    always_comb begin
        mem_wr_rd_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (state == BUSY && gnt_id == ID_WIDTH'(k)) begin
                mem_wr_rd_o   = req_wr_rd_i[k];
                mem_addr_o    = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wr_data_o = req_wr_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign mem_valid_o = (state == BUSY);
    assign busy_o      = (state == BUSY);
    assign gnt_id_o    = gnt_id;
    assign req_ready_o = accept ? gnt_oh : '0;
    assign rsp_valid_o = rsp_pend ? (ONE << rsp_id) : '0;
    assign rsp_data_o  = mem_rd_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: queue-driven requesters, a memory model and
// a transaction-level reference arbiter compared against the DUT every cycle.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 1024;
    localparam int AW = 10;
    localparam int IW = 2;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } op_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid_i, req_wr_rd_i, req_ready_o, rsp_valid_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N*W-1:0]  req_wr_data_i;
    logic [W-1:0]    rsp_data_o, mem_wr_data_o, mem_rd_data_i;
    logic            mem_valid_o, mem_wr_rd_o, mem_ready_i, busy_o;
    logic [AW-1:0]   mem_addr_o;
    logic [IW-1:0]   gnt_id_o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic mem_ready_next;
    logic [N-1:0] rdy_q;
    bit   sweep_on = 1'b0;

    op_t          opq  [N][$];
    logic [W-1:0] expq [N][$];
    int           acc_ids[$];
    int           acc_cyc[$];
    logic [W-1:0] mem_arr [D];

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_wr_rd_i(req_wr_rd_i),
        .req_addr_i(req_addr_i), .req_wr_data_i(req_wr_data_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_ready_i(mem_ready_i),
        .mem_rd_data_i(mem_rd_data_i), .gnt_id_o(gnt_id_o), .busy_o(busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic wr, input int addr, input logic [W-1:0] data);
        op_t o;
        o.wr   = wr;
        o.addr = addr[AW-1:0];
        o.data = data;
        opq[k].push_back(o);
    endtask

    function automatic logic [W-1:0] pat(input int k, input int i);
        return 32'hC0DE_0000 ^ 32'((k << 12) | i);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: write on acceptance, read data registered one cycle later.
    initial for (int a = 0; a < D; a++) mem_arr[a] = '0;
    always @(posedge clk) begin
        if (mem_valid_o && mem_ready_i) begin
            if (mem_wr_rd_o) mem_arr[mem_addr_o] <= mem_wr_data_o;
            else             mem_rd_data_i       <= mem_arr[mem_addr_o];
        end
    end

    // Requesters: present queue heads; pop a head once its ready was seen.
    initial begin
        forever begin
            @(negedge clk);
            rdy_q = req_ready_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++)
                if (rst_n && rdy_q[k] && opq[k].size() > 0) void'(opq[k].pop_front());
            mem_ready_i = mem_ready_next;
            for (int k = 0; k < N; k++) begin
                if (opq[k].size() > 0) begin
                    req_valid_i[k]            = 1'b1;
                    req_wr_rd_i[k]            = opq[k][0].wr;
                    req_addr_i[k*AW +: AW]    = opq[k][0].addr;
                    req_wr_data_i[k*W +: W]   = opq[k][0].data;
                end else begin
                    req_valid_i[k] = 1'b0;
                end
            end
        end
    end

    // Reference: who owns the memory, who went last, what read is in flight.
    bit           m_busy;
    int           m_owner, m_last, m_rsp_id;
    bit           m_pend;
    logic [W-1:0] m_rsp_data;
    logic [W-1:0] m_mem [D];
    initial for (int a = 0; a < D; a++) m_mem[a] = '0;

    function automatic int closest_after(input logic [N-1:0] v, input int base, input int excl);
        for (int d = 1; d <= N; d++)
            if (v[(base + d) % N] && ((base + d) % N) != excl) return (base + d) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int            nxt;
        logic [AW-1:0] a;
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_last  <= N - 1;
            m_pend  <= 1'b0;
        end else begin
            m_pend <= 1'b0;
            if (m_busy && mem_ready_i) begin
                a = req_addr_i[m_owner*AW +: AW];
                if (req_wr_rd_i[m_owner]) begin
                    m_mem[a] <= req_wr_data_i[m_owner*W +: W];
                end else begin
                    m_pend     <= 1'b1;
                    m_rsp_id   <= m_owner;
                    m_rsp_data <= m_mem[a];
                end
                m_last <= m_owner;
                nxt = closest_after(req_valid_i, m_owner, m_owner);
                if (nxt < 0) m_busy  <= 1'b0;
                else         m_owner <= nxt;
            end else if (!m_busy) begin
                nxt = closest_after(req_valid_i, m_last, -1);
                if (nxt >= 0) begin
                    m_busy  <= 1'b1;
                    m_owner <= nxt;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy_o, m_busy);
            check("mem_valid", mem_valid_o, m_busy);
            check("req_ready", req_ready_o, (m_busy && mem_ready_i) ? (4'b1 << m_owner) : 4'b0);
            check("rsp_valid", rsp_valid_o, m_pend ? (4'b1 << m_rsp_id) : 4'b0);
            if (m_pend) check("rsp_data", rsp_data_o, m_rsp_data);
            if (m_busy) begin
                check("gnt_id", gnt_id_o, m_owner);
                check("mem_wr_rd", mem_wr_rd_o, req_wr_rd_i[m_owner]);
                check("mem_addr", mem_addr_o, req_addr_i[m_owner*AW +: AW]);
                check("mem_wr_data", mem_wr_data_o, req_wr_data_i[m_owner*W +: W]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (req_ready_o[k]) begin
                    acc_ids.push_back(k);
                    acc_cyc.push_back(cyc);
                end
                if (sweep_on && rsp_valid_o[k]) begin
                    if (expq[k].size() == 0) check("sweep_extra_rsp", 1, 0);
                    else check("sweep_data", rsp_data_o, expq[k].pop_front());
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int bound);
        int t;
        for (t = 0; t < bound; t++) begin
            @(negedge clk);
            if (!busy_o && opq[0].size() == 0 && opq[1].size() == 0 &&
                opq[2].size() == 0 && opq[3].size() == 0) break;
        end
        check(name, (t < bound), 1);
        @(negedge clk);
    endtask

    initial begin : main
        int t, errs, cnt;
        rst_n = 1'b0;
        req_valid_i = '0; req_wr_rd_i = '0; req_addr_i = '0; req_wr_data_i = '0;
        mem_ready_i = 1'b1; mem_ready_next = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_mem_valid", mem_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_gnt_id", gnt_id_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        #1 rst_n = 1'b1;

        // Reset in the middle of a busy period with a read response due.
        push(1, 1'b0, 7, 0);
        push(3, 1'b0, 8, 0);
        for (t = 0; t < 20 && !req_ready_o[1]; t++) @(negedge clk);
        check("wait_rdy1", req_ready_o[1], 1);
        @(negedge clk);
        check("pre_rst_rsp", rsp_valid_o, 4'b0010);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_mem_valid", mem_valid_o, 0);
        check("mid_rst_req_ready", req_ready_o, 0);
        check("mid_rst_rsp_valid", rsp_valid_o, 0);
        check("mid_rst_gnt", gnt_id_o, 0);
        check("mid_rst_addr", mem_addr_o, 0);
        for (int k = 0; k < N; k++) opq[k].delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rsp", rsp_valid_o, 0);
        end
        push(2, 1'b1, 40, 32'h1234);
        for (t = 0; t < 10 && !busy_o; t++) @(negedge clk);
        check("post_rst_gnt2", gnt_id_o, 2);
        wait_idle("idle_rst", 20);

        // Lone requester: write then read, with an idle cycle between grants.
        push(0, 1'b1, 5, 32'hDEADBEEF);
        push(0, 1'b0, 5, 0);
        for (t = 0; t < 10 && !mem_valid_o; t++) @(negedge clk);
        check("single_valid_1", mem_valid_o, 1);
        @(negedge clk);
        check("single_valid_0", mem_valid_o, 0);
        @(negedge clk);
        check("single_valid_1b", mem_valid_o, 1);
        @(negedge clk);
        check("single_rsp_valid", rsp_valid_o, 4'b0001);
        check("single_rsp_data", rsp_data_o, 32'hDEADBEEF);
        wait_idle("idle_single", 20);

        // Fairness: 4 x 25 writes; last owner was 0, so rotation starts at 1.
        acc_ids.delete(); acc_cyc.delete();
        for (int i = 0; i < 25; i++)
            for (int k = 0; k < N; k++) push(k, 1'b1, k*256 + 128 + i, pat(k, i));
        wait_idle("idle_fair", 300);
        check("fair_total", acc_ids.size(), 100);
        if (acc_ids.size() == 100) begin
            errs = 0;
            for (int i = 0; i < 100; i++) if (acc_ids[i] != (1 + i) % N) errs++;
            check("fair_first", acc_ids[0], 1);
            check("fair_order_errs", errs, 0);
            check("fair_no_gap", acc_cyc[99] - acc_cyc[0], 99);
            for (int k = 0; k < N; k++) begin
                cnt = 0;
                foreach (acc_ids[i]) if (acc_ids[i] == k) cnt++;
                check("fair_share", cnt, 25);
            end
        end

        // Backpressure: requester 1 granted while the memory stalls.
        mem_ready_next = 1'b0;
        @(negedge clk);
        push(1, 1'b1, 30, 32'h1111_0030);
        push(3, 1'b1, 31, 32'h3333_0031);
        for (t = 0; t < 10 && !busy_o; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_gnt", gnt_id_o, 1);
            check("bp_no_ready", req_ready_o, 0);
            check("bp_addr", mem_addr_o, 30);
            if (i == 4) mem_ready_next = 1'b1;
            @(negedge clk);
        end
        check("bp_accept1", req_ready_o, 4'b0010);
        @(negedge clk);
        check("bp_accept3", req_ready_o, 4'b1000);
        wait_idle("idle_bp", 20);

        // Read routing: back-to-back reads from requesters 2 and 3.
        push(0, 1'b1, 10, 32'hA1A1_A1A1);
        push(0, 1'b1, 11, 32'hB2B2_B2B2);
        wait_idle("idle_prep", 20);
        push(2, 1'b0, 10, 0);
        push(3, 1'b0, 11, 0);
        for (t = 0; t < 10 && !req_ready_o[2]; t++) @(negedge clk);
        check("route_rdy2", req_ready_o[2], 1);
        @(negedge clk);
        check("route_rsp2", rsp_valid_o, 4'b0100);
        check("route_data2", rsp_data_o, 32'hA1A1_A1A1);
        check("route_rdy3", req_ready_o, 4'b1000);
        @(negedge clk);
        check("route_rsp3", rsp_valid_o, 4'b1000);
        check("route_data3", rsp_data_o, 32'hB2B2_B2B2);
        wait_idle("idle_route", 20);

        // Quarter sweep: each requester writes then reads its own quarter.
        sweep_on = 1'b1;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < D/4; i++) push(k, 1'b1, k*(D/4) + i, pat(k, i) ^ 32'h5A5A_0000);
            for (int i = 0; i < D/4; i++) begin
                push(k, 1'b0, k*(D/4) + i, 0);
                expq[k].push_back(pat(k, i) ^ 32'h5A5A_0000);
            end
        end
        wait_idle("idle_sweep", 4000);
        @(negedge clk);
        sweep_on = 1'b0;
        for (int k = 0; k < N; k++) check("sweep_left", expq[k].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
